// File: rtl/rx_qam_demap.sv
// rx_qam_demap: drops null/pilot carriers, hard-demaps QPSK/16QAM/64QAM and packs bits MSB-first into bytes.
// Optional symbol counter port SYM_CNT_O when RX_QAM_DEMAP_SYMCNT_EN is defined.
module rx_qam_demap #(
  parameter int NFFT          = 2048,
  parameter int NUSED_HALF    = 840,
  parameter int PILOT_SPACING = 7,
  parameter int THR16         = 5181,
  parameter int THR64_1       = 2528,
  parameter int THR64_2       = 5056,
  parameter int THR64_3       = 7584
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic [1:0]  MOD_I,
  output logic [7:0]  DAT_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic        CYC_O,
`ifdef RX_QAM_DEMAP_SYMCNT_EN
  output logic [15:0] SYM_CNT_O,
`endif
  input  logic        ACK_I
);
  localparam int KW = $clog2(NFFT);
  localparam int PW = $clog2(PILOT_SPACING);
  localparam logic [KW-1:0] K_LO = KW'(NUSED_HALF);
  localparam logic [KW-1:0] K_HI = KW'(NFFT - NUSED_HALF);
  localparam logic [KW-1:0] K_LAST = KW'(NFFT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PILOT_SPACING - 1);
  logic [KW-1:0] k;
  logic [PW-1:0] p;
  logic [1:0]    mod_r;
  logic [13:0]   acc;
  logic [3:0]    nb;
  logic          xfer, used, data;
  logic [3:0]    di, dq;
  logic [5:0]    bits;
  logic [2:0]    n;
  logic [19:0]   cat;
  logic [4:0]    tot;
  logic [7:0]    byte_nxt;
  logic          unused;
  // Returns {sign, |x|<THR16, |x|<THR64_2, THR64_1<=|x|<THR64_3}
  function automatic logic [3:0] ax(input logic [15:0] x);
    logic [15:0] a;
    a = x[15] ? ((x == 16'h8000) ? 16'h7fff : -x) : x;
    return {x[15], a < 16'(THR16), a < 16'(THR64_2), (a >= 16'(THR64_1)) & (a < 16'(THR64_3))};
  endfunction
  assign ACK_O  = CYC_I & STB_I & (~STB_O | ACK_I);
  assign WE_O   = STB_O;
  assign unused = WE_I;
  always_comb begin
    xfer = CYC_I & STB_I & ACK_O;
    used = ((k != '0) && (k <= K_LO)) || (k >= K_HI);
    data = used && (p != '0);
    di = ax(DAT_I[15:0]);
    dq = ax(DAT_I[31:16]);
    n = (mod_r == 2'd2) ? 3'd6 : (mod_r == 2'd1) ? 3'd4 : 3'd2;
    bits = (mod_r == 2'd2) ? {di[3], di[1], di[0], dq[3], dq[1], dq[0]} :
           (mod_r == 2'd1) ? {2'b0, di[3], di[2], dq[3], dq[2]} : {4'b0, di[3], dq[3]};
    cat = ({6'b0, acc} << n) | {14'b0, bits};
    tot = 5'(nb) + 5'(n);
    byte_nxt = 8'(cat >> (tot - 5'd8));
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      k <= '0;
      p <= '0;
      mod_r <= '0;
      acc <= '0;
      nb <= '0;
      DAT_O <= '0;
      STB_O <= 1'b0;
      CYC_O <= 1'b0;
    end else begin
      if (!CYC_I) begin
        k <= '0;
        p <= '0;
        acc <= '0;
        nb <= '0;
      end else if (xfer) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
        if (k == '0) mod_r <= MOD_I;
        if (k == K_LAST) p <= '0;
        else if (used) p <= (p == P_LAST) ? '0 : p + 1'b1;
        if (data) begin
          acc <= cat[13:0];
          nb <= (tot >= 5'd8) ? 4'(tot - 5'd8) : 4'(tot);
        end
      end
      // A new byte can only complete when the output slot is free or being accepted
      if (xfer && data && tot >= 5'd8) begin
        DAT_O <= byte_nxt;
        STB_O <= 1'b1;
      end else if (ACK_I) STB_O <= 1'b0;
      if (xfer) CYC_O <= 1'b1;
      else if (!CYC_I && !STB_O) CYC_O <= 1'b0;
    end
  end
`ifdef RX_QAM_DEMAP_SYMCNT_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) SYM_CNT_O <= '0;
    else if (xfer && k == K_LAST) SYM_CNT_O <= SYM_CNT_O + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rx_qam_demap.sv
// tb_rx_qam_demap: directed-symbol bench for rx_qam_demap with hand-computed byte patterns.
module tb_rx_qam_demap;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cyc_i, stb_i, we_i, ack_o, stb_o, we_o, cyc_o, ack_i;
  logic [31:0] dat_i;
  logic [1:0] mod_i;
  logic [7:0] dat_o;
`ifdef RX_QAM_DEMAP_SYMCNT_EN
  logic [15:0] sym_cnt;
`endif
  int tests = 0;
  int fails = 0;
  int nb, ne, pe, ns;
  rx_qam_demap dut (
    .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i),
    .ACK_O(ack_o), .MOD_I(mod_i), .DAT_O(dat_o), .STB_O(stb_o), .WE_O(we_o), .CYC_O(cyc_o),
`ifdef RX_QAM_DEMAP_SYMCNT_EN
    .SYM_CNT_O(sym_cnt),
`endif
    .ACK_I(ack_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Streams nsamp samples; data carriers get (id,qd), DC/guard/pilot carriers get (ix,qx).
  task automatic run_sym(input logic [1:0] m, input logic [15:0] id, input logic [15:0] qd,
                         input logic [15:0] ix, input logic [15:0] qx, input int nsamp,
                         input bit bp, input bit drain, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, output int nbytes, output int nerr, output int perr,
                         output int nsent);
    int s = 0, u = 0, cyc = 0, tail = 0, kk;
    bit used = 0, data, started = 0, prev_stall = 0;
    logic [7:0] prev_dat = '0, e;
    nbytes = 0; nerr = 0; perr = 0;
    cyc_i = 1'b1;
    while ((s < nsamp || (drain && tail < 4)) && cyc < 4 * nsamp + 200) begin
      @(negedge clk);
      if (s >= nsamp) tail = stb_o ? 0 : tail + 1;
      ack_i = bp ? (cyc % 3 == 0) : 1'b1;
      if (s < nsamp) begin
        kk = s % 2048;
        used = (kk >= 1 && kk <= 840) || kk >= 1208;
        data = used && (u % 7 != 0);
        dat_i = data ? {qd, id} : {qx, ix};
        mod_i = (kk == 0) ? m : (m == 2'd2 ? 2'd0 : 2'd2);
        stb_i = 1'b1;
      end else stb_i = 1'b0;
      #1;
      if (prev_stall && (stb_o !== 1'b1 || dat_o !== prev_dat)) perr++;
      if (we_o !== stb_o) perr++;
      if (stb_o && !ack_i && ack_o !== 1'b0) perr++;
      if (started && cyc_o !== 1'b1) perr++;
      if (stb_o === 1'b1 && ack_i) begin
        e = (nbytes % 3 == 0) ? p0 : (nbytes % 3 == 1) ? p1 : p2;
        if (dat_o !== e) nerr++;
        nbytes++;
      end
      prev_stall = stb_o && !ack_i;
      prev_dat = dat_o;
      if (stb_i && ack_o) begin
        if (used) u++;
        s++;
        started = 1;
      end
      cyc++;
    end
    stb_i = 1'b0;
    nsent = s;
  endtask
  task automatic idle(input int n);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b1; ack_i = 1'b0; mod_i = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_stb", stb_o, 1'b0);
    chk("rst_we", we_o, 1'b0);
    chk("rst_cyc", cyc_o, 1'b0);
    chk("idle_ack", ack_o, 1'b0);
`ifdef RX_QAM_DEMAP_SYMCNT_EN
    chk("rst_symcnt", sym_cnt, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_sym(2'd0, 16'h1000, 16'hF000, 16'h1000, 16'hF000, 2048, 0, 1, 8'h55, 8'h55, 8'h55, nb, ne, pe, ns);
    chk("qpsk_samples", ns, 2048);
    chk("qpsk_bytes", nb, 360);
    chk("qpsk_data", ne, 0);
    chk("qpsk_proto", pe, 0);
    chk("qpsk_cyc_hold", cyc_o, 1'b1);
    @(negedge clk);
    cyc_i = 1'b0;
    @(negedge clk);
    #1;
    chk("qpsk_cyc_fall", cyc_o, 1'b0);
    idle(2);
    run_sym(2'd1, 16'(2000), 16'(-8000), 16'(2000), 16'(-8000), 2048, 0, 1, 8'h66, 8'h66, 8'h66, nb, ne, pe, ns);
    chk("qam16_bytes", nb, 720);
    chk("qam16_data", ne, 0);
    chk("qam16_proto", pe, 0);
    idle(2);
    run_sym(2'd2, 16'(3000), 16'(9000), 16'(3000), 16'(9000), 2048, 0, 1, 8'h61, 8'h86, 8'h18, nb, ne, pe, ns);
    chk("qam64_bytes", nb, 1080);
    chk("qam64_data", ne, 0);
    chk("qam64_proto", pe, 0);
    idle(2);
    run_sym(2'd0, 16'h1000, 16'h1000, 16'hF000, 16'hF000, 2048, 0, 1, 8'h00, 8'h00, 8'h00, nb, ne, pe, ns);
    chk("pilot_bytes", nb, 360);
    chk("pilot_data", ne, 0);
    idle(2);
    run_sym(2'd1, 16'(2000), 16'(-8000), 16'(2000), 16'(-8000), 2048, 1, 1, 8'h66, 8'h66, 8'h66, nb, ne, pe, ns);
    chk("bp_samples", ns, 2048);
    chk("bp_bytes", nb, 720);
    chk("bp_data", ne, 0);
    chk("bp_proto", pe, 0);
    idle(2);
    // Saturating |-32768| and the exact THR64_1 / THR16 edges
    run_sym(2'd2, 16'h8000, 16'(-2528), 16'h8000, 16'(-2528), 2048, 0, 1, 8'h9E, 8'h79, 8'hE7, nb, ne, pe, ns);
    chk("sat64_bytes", nb, 1080);
    chk("sat64_data", ne, 0);
    idle(2);
    run_sym(2'd1, 16'(5181), 16'(-5180), 16'(5181), 16'(-5180), 2048, 0, 1, 8'h33, 8'h33, 8'h33, nb, ne, pe, ns);
    chk("thr16_bytes", nb, 720);
    chk("thr16_data", ne, 0);
    idle(2);
    run_sym(2'd0, 16'h1000, 16'hF000, 16'h1000, 16'hF000, 500, 0, 1, 8'h55, 8'h55, 8'h55, nb, ne, pe, ns);
    idle(2);
    run_sym(2'd0, 16'h1000, 16'hF000, 16'h1000, 16'hF000, 2048, 0, 1, 8'h55, 8'h55, 8'h55, nb, ne, pe, ns);
    chk("abort_bytes", nb, 360);
    chk("abort_data", ne, 0);
    idle(2);
    run_sym(2'd1, 16'(2000), 16'(-8000), 16'(2000), 16'(-8000), 400, 1, 0, 8'h66, 8'h66, 8'h66, nb, ne, pe, ns);
    @(negedge clk);
    ack_i = 1'b0;
    stb_i = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_rst_pending", stb_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    stb_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_dat", dat_o, 8'h00);
    chk("mid_rst_stb", stb_o, 1'b0);
    chk("mid_rst_we", we_o, 1'b0);
    chk("mid_rst_cyc", cyc_o, 1'b0);
`ifdef RX_QAM_DEMAP_SYMCNT_EN
    chk("mid_rst_symcnt", sym_cnt, 16'd0);
`endif
    rst = 1'b0;
    idle(2);
    run_sym(2'd0, 16'h1000, 16'hF000, 16'h1000, 16'hF000, 2048, 0, 1, 8'h55, 8'h55, 8'h55, nb, ne, pe, ns);
    chk("post_rst_bytes", nb, 360);
    chk("post_rst_data", ne, 0);
`ifdef RX_QAM_DEMAP_SYMCNT_EN
    chk("symcnt_one", sym_cnt, 16'd1);
`endif
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
